// File: rtl/aes_inv_cipher_sequencer_pkg.sv
// Shared encodings for the AES-128 inverse-cipher sequencer.
package aes_inv_cipher_sequencer_pkg;

  localparam int unsigned AES_BLOCK_W = 128;

  // stepSel values driven to the inverse step-unit mux.
  typedef enum logic [1:0] {
    STEP_ISR = 2'd0,
    STEP_ISB = 2'd1,
    STEP_ARK = 2'd2,
    STEP_IMC = 2'd3
  } stepSel_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seqState_e;

endpackage

// File: rtl/aes_inv_cipher_sequencer_inv_step_decode.sv
// Maps a step index of the inverse cipher onto the step unit to fire,
// the round key it needs and whether it is the final step.
module inv_step_decode
  import aes_inv_cipher_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic [5:0] stepIdx,
  output logic [1:0] stepSel,
  output logic       isArk,
  output logic [3:0] keyIndex,
  output logic       isLast
);

  localparam int unsigned NUM_STEPS = 4 * NUM_ROUNDS;

  logic [5:0] bodyIdx;

  // Step 0 is the lone initial AddRoundKey; afterwards steps come in groups of
  // four (ISR, ISB, ARK, IMC) with one key per group, the last group ending at ARK.
  always_comb begin
    bodyIdx  = stepIdx - 6'd1;
    stepSel  = STEP_ARK;
    keyIndex = 4'(NUM_ROUNDS);
    if (stepIdx != '0) begin
      stepSel  = bodyIdx[1:0];
      keyIndex = 4'(NUM_ROUNDS - 1) - bodyIdx[5:2];
    end
    isArk  = (stepSel == STEP_ARK);
    isLast = (stepIdx == 6'(NUM_STEPS - 1));
  end

endmodule

// File: rtl/aes_inv_cipher_sequencer.sv
// AES-128 inverse-cipher sequencer: owns the working state, strobes the
// external inverse step units one at a time and collects their results.
module aes_inv_cipher_sequencer
  import aes_inv_cipher_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS   = 10,
  parameter int unsigned STEP_LATENCY = 2
) (
  input  logic                   clock,
  input  logic                   nReset,
  input  logic                   startDecrypt,
  input  logic [AES_BLOCK_W-1:0] cipherText,
  output logic [AES_BLOCK_W-1:0] stepData,
  output logic [1:0]             stepSel,
  output logic                   stepStrobe,
  input  logic [AES_BLOCK_W-1:0] stepResult,
  output logic [3:0]             roundKeyAddr,
  output logic [AES_BLOCK_W-1:0] plainText,
  output logic                   busy,
  output logic                   done
);

  seqState_e  state;
  seqState_e  stateNext;
  logic [5:0] stepCnt;
  logic [5:0] decIdx;
  logic [2:0] waitCnt;
  logic       lastStep;
  logic       accept;
  logic       capture;
  logic       enterIssue;
  logic [1:0] decSel;
  logic       decArk;
  logic [3:0] decKey;
  logic       decLast;

  // The decoder always looks at the step about to enter ISSUE, so stepSel,
  // roundKeyAddr and the last-step flag are registered exactly on ISSUE entry.
  inv_step_decode #(
    .NUM_ROUNDS(NUM_ROUNDS)
  ) stepDecode (
    .stepIdx (decIdx),
    .stepSel (decSel),
    .isArk   (decArk),
    .keyIndex(decKey),
    .isLast  (decLast)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state logic, step-advance qualifiers and state-derived outputs.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    capture   = 1'b0;
    decIdx    = stepCnt + 6'd1;
    unique case (state)
      IDLE: begin
        decIdx = '0;
        if (startDecrypt) begin
          accept    = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: stateNext = WAIT;
      WAIT: begin
        if (waitCnt == 3'(STEP_LATENCY - 1)) begin
          capture   = 1'b1;
          stateNext = lastStep ? DONE : ISSUE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    enterIssue = accept | (capture & ~lastStep);
    stepStrobe = (state == ISSUE);
    busy       = (state == ISSUE) || (state == WAIT);
    done       = (state == DONE);
  end

  // Working state, result, step bookkeeping and latency counter.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      stepData     <= '0;
      plainText    <= '0;
      stepSel      <= STEP_ISR;
      roundKeyAddr <= 4'(NUM_ROUNDS);
      stepCnt      <= '0;
      waitCnt      <= '0;
      lastStep     <= 1'b0;
    end else begin
      if (accept)       stepData <= cipherText;
      else if (capture) stepData <= stepResult;

      if (capture && lastStep) plainText <= stepResult;

      if (enterIssue) begin
        stepCnt  <= decIdx;
        stepSel  <= decSel;
        lastStep <= decLast;
        if (decArk) roundKeyAddr <= decKey;
      end

      if (state == ISSUE)     waitCnt <= '0;
      else if (state == WAIT) waitCnt <= waitCnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_sequencer.sv
// Bench for aes_inv_cipher_sequencer with behavioural inverse step units.
module tb_aes_inv_cipher_sequencer;

  localparam int NI = 3;
  localparam logic [127:0] CIPHER = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PLAIN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY    = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clock = 1'b0;
  logic         nReset;
  logic [127:0] cipherText;
  logic         startDecrypt [NI];
  logic [127:0] stepData     [NI];
  logic [1:0]   stepSel      [NI];
  logic         stepStrobe   [NI];
  logic [127:0] stepResult   [NI];
  logic [3:0]   roundKeyAddr [NI];
  logic [127:0] plainText    [NI];
  logic         busy         [NI];
  logic         done         [NI];

  always #5 clock = ~clock;

  aes_inv_cipher_sequencer #(.NUM_ROUNDS(10), .STEP_LATENCY(2)) dut (
    .clock(clock), .nReset(nReset), .startDecrypt(startDecrypt[0]), .cipherText(cipherText),
    .stepData(stepData[0]), .stepSel(stepSel[0]), .stepStrobe(stepStrobe[0]),
    .stepResult(stepResult[0]), .roundKeyAddr(roundKeyAddr[0]), .plainText(plainText[0]),
    .busy(busy[0]), .done(done[0]));

  aes_inv_cipher_sequencer #(.NUM_ROUNDS(10), .STEP_LATENCY(1)) dutL1 (
    .clock(clock), .nReset(nReset), .startDecrypt(startDecrypt[1]), .cipherText(cipherText),
    .stepData(stepData[1]), .stepSel(stepSel[1]), .stepStrobe(stepStrobe[1]),
    .stepResult(stepResult[1]), .roundKeyAddr(roundKeyAddr[1]), .plainText(plainText[1]),
    .busy(busy[1]), .done(done[1]));

  aes_inv_cipher_sequencer #(.NUM_ROUNDS(10), .STEP_LATENCY(7)) dutL7 (
    .clock(clock), .nReset(nReset), .startDecrypt(startDecrypt[2]), .cipherText(cipherText),
    .stepData(stepData[2]), .stepSel(stepSel[2]), .stepStrobe(stepStrobe[2]),
    .stepResult(stepResult[2]), .roundKeyAddr(roundKeyAddr[2]), .plainText(plainText[2]),
    .busy(busy[2]), .done(done[2]));

  // ---------------- AES reference arithmetic ----------------
  logic [7:0]   sbox     [256];
  logic [7:0]   invSbox  [256];
  logic [127:0] roundKey [16];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  task automatic buildTables();
    logic [7:0]  inv;
    logic [7:0]  s;
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]    = s;
      invSbox[s] = 8'(x);
    end
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) roundKey[r] = '0;
    for (int r = 0; r < 11; r++) roundKey[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] applyStep(input logic [1:0] sel, input logic [127:0] s, input logic [3:0] k);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = s;
    case (sel)
      2'd0: for (int c = 0; c < 4; c++)
              for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      2'd1: for (int i = 0; i < 16; i++) o[127-8*i -: 8] = invSbox[s[127-8*i -: 8]];
      2'd2: o = s ^ roundKey[k];
      default: for (int c = 0; c < 4; c++) begin
        a0 = s[127-32*c -: 8];
        a1 = s[119-32*c -: 8];
        a2 = s[111-32*c -: 8];
        a3 = s[103-32*c -: 8];
        o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
        o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
        o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
        o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
      end
    endcase
    return o;
  endfunction

  // ---------------- behavioural step units ----------------
  // Result appears stepLatency cycles after the strobe; random noise otherwise.
  logic [127:0] pendRes [NI];
  logic [127:0] noise   [NI];
  int unsigned  latCnt  [NI];

  function automatic int unsigned latOf(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 7;
    endcase
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < NI; i++) begin
      noise[i] <= {$urandom, $urandom, $urandom, $urandom};
      if (stepStrobe[i]) begin
        pendRes[i] <= applyStep(stepSel[i], stepData[i], roundKeyAddr[i]);
        latCnt[i]  <= 1;
      end else if (latCnt[i] != 0 && latCnt[i] < latOf(i)) begin
        latCnt[i] <= latCnt[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++)
      stepResult[i] = (latCnt[i] == latOf(i)) ? pendRes[i] : noise[i];
  end

  // ---------------- monitors and scoreboard ----------------
  typedef struct { int inst; int cyc; logic [127:0] pt; } doneEv_t;
  typedef struct { int cyc; logic [1:0] sel; logic [3:0] key; } strobeEv_t;

  doneEv_t   doneQ   [$];
  doneEv_t   expQ    [$];
  strobeEv_t strobeQ [$];
  int        cyc = 0;
  int        busyCnt [NI];
  int        rdIdx = 0;
  int        total = 0;
  int        bad = 0;

  function automatic doneEv_t mkDone(input int i, input int c, input logic [127:0] p);
    doneEv_t e;
    e.inst = i;
    e.cyc  = c;
    e.pt   = p;
    return e;
  endfunction

  function automatic strobeEv_t mkStrobe(input int c, input logic [1:0] s, input logic [3:0] k);
    strobeEv_t e;
    e.cyc = c;
    e.sel = s;
    e.key = k;
    return e;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      if (done[i]) doneQ.push_back(mkDone(i, cyc, plainText[i]));
      if (busy[i]) busyCnt[i] <= busyCnt[i] + 1;
    end
    if (stepStrobe[0]) strobeQ.push_back(mkStrobe(cyc, stepSel[0], roundKeyAddr[0]));
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drain(input string tag);
    doneEv_t e;
    doneEv_t g;
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      check({tag, " done seen"}, 128'(doneQ.size() > rdIdx), 128'(1'b1));
      if (doneQ.size() > rdIdx) begin
        g = doneQ[rdIdx];
        rdIdx++;
        check({tag, " inst"}, 128'(g.inst), 128'(e.inst));
        check({tag, " done cycle"}, 128'(g.cyc), 128'(e.cyc));
        check({tag, " plaintext"}, g.pt, e.pt);
      end
    end
    check({tag, " no extra done"}, 128'(doneQ.size()), 128'(rdIdx));
  endtask

  task automatic waitCyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic waitDone(input int n, input int limit);
    int target;
    int k;
    target = rdIdx + n;
    k = 0;
    while (doneQ.size() < target && k < limit) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic pulseStart(input logic [NI-1:0] mask, output int acc);
    for (int i = 0; i < NI; i++) if (mask[i]) startDecrypt[i] = 1'b1;
    @(negedge clock);
    for (int i = 0; i < NI; i++) startDecrypt[i] = 1'b0;
    acc = cyc;
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, " stepData"}, stepData[0], '0);
    check({tag, " plainText"}, plainText[0], '0);
    check({tag, " stepSel"}, 128'(stepSel[0]), 128'(2'd0));
    check({tag, " stepStrobe"}, 128'(stepStrobe[0]), 128'(1'b0));
    check({tag, " roundKeyAddr"}, 128'(roundKeyAddr[0]), 128'(4'd10));
    check({tag, " busy"}, 128'(busy[0]), 128'(1'b0));
    check({tag, " done"}, 128'(done[0]), 128'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the test sequence");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int         a;
    int         base;
    int         b0;
    logic [3:0] held;
    logic [1:0] eSel [$];
    logic [3:0] eKey [$];
    strobeEv_t  se;

    nReset     = 1'b0;
    cipherText = CIPHER;
    for (int i = 0; i < NI; i++) startDecrypt[i] = 1'b0;
    buildTables();
    repeat (3) @(negedge clock);
    checkIdleOutputs("reset");
    nReset = 1'b1;
    repeat (2) @(negedge clock);

    // FIPS-197 C.1 decryption plus strobe sequence log.
    base = strobeQ.size();
    b0   = busyCnt[0];
    pulseStart(3'b001, a);
    expQ.push_back(mkDone(0, a + 120, PLAIN));
    cipherText = {$urandom, $urandom, $urandom, $urandom};
    waitDone(1, 200);
    waitCyc(a + 125);
    drain("c1");
    check("c1 busy cycles", 128'(busyCnt[0] - b0), 128'(120));
    check("c1 plaintext held", plainText[0], PLAIN);
    check("c1 stepData final", stepData[0], PLAIN);
    check("c1 busy low", 128'(busy[0]), 128'(1'b0));

    eSel.push_back(2'd2); eKey.push_back(4'd10);
    held = 4'd10;
    for (int r = 9; r >= 1; r--) begin
      eSel.push_back(2'd0); eKey.push_back(held);
      eSel.push_back(2'd1); eKey.push_back(held);
      held = 4'(r);
      eSel.push_back(2'd2); eKey.push_back(held);
      eSel.push_back(2'd3); eKey.push_back(held);
    end
    eSel.push_back(2'd0); eKey.push_back(held);
    eSel.push_back(2'd1); eKey.push_back(held);
    eSel.push_back(2'd2); eKey.push_back(4'd0);
    check("seq strobe count", 128'(strobeQ.size() - base), 128'(40));
    for (int k = 0; k < 40; k++) begin
      if (base + k < strobeQ.size()) begin
        se = strobeQ[base + k];
        check($sformatf("seq sel[%0d]", k), 128'(se.sel), 128'(eSel[k]));
        check($sformatf("seq key[%0d]", k), 128'(se.key), 128'(eKey[k]));
        check($sformatf("seq cycle[%0d]", k), 128'(se.cyc), 128'(a + 3 * k));
      end
    end
    cipherText = CIPHER;

    // Start requests while busy and in DONE are ignored.
    pulseStart(3'b001, a);
    expQ.push_back(mkDone(0, a + 120, PLAIN));
    waitCyc(a + 9);   pulseStart(3'b001, b0);
    waitCyc(a + 59);  pulseStart(3'b001, b0);
    waitCyc(a + 119);
    startDecrypt[0] = 1'b1;
    waitCyc(a + 121);
    startDecrypt[0] = 1'b0;
    waitCyc(a + 150);
    drain("busy-start");
    check("busy-start idle", 128'(busy[0]), 128'(1'b0));

    // Asynchronous reset mid-block, then a fresh block.
    pulseStart(3'b001, a);
    waitCyc(a + 50);
    #2 nReset = 1'b0;
    #1;
    checkIdleOutputs("mid-reset");
    waitCyc(a + 55);
    nReset = 1'b1;
    waitCyc(a + 130);
    drain("mid-reset");
    pulseStart(3'b001, a);
    expQ.push_back(mkDone(0, a + 120, PLAIN));
    waitDone(1, 200);
    waitCyc(a + 125);
    drain("after-reset");

    // Latency sweep on the L=1 and L=7 instances.
    pulseStart(3'b110, a);
    expQ.push_back(mkDone(1, a + 80, PLAIN));
    expQ.push_back(mkDone(2, a + 320, PLAIN));
    waitDone(2, 400);
    waitCyc(a + 325);
    drain("sweep");

    // Back-to-back blocks with startDecrypt held high.
    startDecrypt[0] = 1'b1;
    @(negedge clock);
    a = cyc;
    expQ.push_back(mkDone(0, a + 120, PLAIN));
    expQ.push_back(mkDone(0, a + 242, PLAIN));
    waitDone(2, 300);
    startDecrypt[0] = 1'b0;
    repeat (10) @(negedge clock);
    drain("b2b");
    check("b2b idle", 128'(busy[0]), 128'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_sequencer.md
Name: aes_inv_cipher_sequencer

Overview:
Control block for the AES-128 decryption datapath.
- Owns the 128-bit working state register.
- Issues one-cycle strobes to the edge-triggered inverse step units (inv_shift_row, inv_sub_bytes, add_round_key, inv_mix_columns) and captures their results.
- Drives the round-key address toward key storage.
- Sits between the data-communication front end (which supplies cipher text) and plaintext output.

Parameters:
NUM_ROUNDS, 10, cipher rounds (AES-128); fixes step count NUM_STEPS = 4*NUM_ROUNDS.
STEP_LATENCY, 2, cycles from stepStrobe high to stepResult valid; legal range 1..7.

Ports:
clock  input  1  system clock; all state on rising edge.
nReset  input  1  asynchronous, active-low reset.
startDecrypt  input  1  request; sampled only in IDLE.
cipherText  input  128  block captured when startDecrypt is accepted.
stepData  output  128  current state register, presented to the step units.
stepSel  output  2  0 InvShiftRow, 1 InvSubBytes, 2 AddRoundKey, 3 InvMixColumns.
stepStrobe  output  1  one-cycle pulse; wired to the units' startTransition.
stepResult  input  128  selected unit's output (muxed externally by stepSel).
roundKeyAddr  output  4  round-key index for the AddRoundKey unit.
plainText  output  128  final result, held until next completion.
busy  output  1  high while a block is in flight.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (nReset low, async): FSM=IDLE; stepData, plainText = 0; stepSel=0; stepStrobe=0; roundKeyAddr=NUM_ROUNDS; busy=0; done=0; step and wait counters=0.
- Step order (NUM_STEPS=40 for default):
  - step 0: ARK(key NUM_ROUNDS)
  - for r = NUM_ROUNDS-1 down to 1: ISR, ISB, ARK(key r), IMC
  - final: ISR, ISB, ARK(key 0)
- roundKeyAddr:
  - set to the step's key index in the ISSUE cycle of each ARK step.
  - held unchanged through non-ARK steps.
  - decrements NUM_ROUNDS..0.
- States:
  - IDLE: busy=0. On startDecrypt=1: state reg <= cipherText, step=0 -> ISSUE.
  - ISSUE: stepStrobe=1 for exactly this cycle; stepSel/roundKeyAddr valid this cycle and held through WAIT. waitCnt <= 0 -> WAIT.
  - WAIT: count cycles. On the STEP_LATENCY-th WAIT cycle edge: state reg <= stepResult; step++.
    - If last step: plainText <= stepResult -> DONE.
    - Otherwise -> ISSUE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE unconditionally.
- Timing:
  - Each step takes exactly 1+STEP_LATENCY cycles.
  - done is high in the cycle beginning NUM_STEPS*(1+STEP_LATENCY) edges after the edge that accepted start (default 120).
- busy is high in ISSUE and WAIT only.
- stepSel and stepData are stable from ISSUE until capture; they change only on ISSUE entry or capture.
- startDecrypt in ISSUE/WAIT/DONE: ignored, not queued. In DONE it has no effect; it must be re-presented in IDLE.
- startDecrypt held high continuously: back-to-back blocks, one IDLE cycle between done and the next ISSUE.
- Reset mid-operation: immediate abort to the reset values above. No done pulse; the prior plainText is cleared.
- cipherText changes after acceptance have no effect.
- stepResult is ignored except on capture edges.

Decomposition:
- Shared header aes_defines.vh holds:
  - stepSel encodings (STEP_ISR=0, STEP_ISB=1, STEP_ARK=2, STEP_IMC=3)
  - FSM state encodings (IDLE, ISSUE, WAIT, DONE)
  - AES_BLOCK_W=128
- One sub-module, inv_step_decode: combinational step index (6 bits) + NUM_ROUNDS -> stepSel, isArk, keyIndex, isLast.
- The top module holds the FSM, counters and registers.

Test Plan:
- FIPS-197 C.1 with behavioural step units (L=2) and key schedule for key 000102030405060708090a0b0c0d0e0f:
  - cipherText 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse.
  - Required: done exactly 120 cycles after accepting edge; plainText 00112233445566778899aabbccddeeff; busy high 120 cycles.
- Sequence check:
  - Log stepSel and roundKeyAddr at each stepStrobe.
  - Required: 40 strobes; stepSel order 2,(0,1,2,3)x9,0,1,2; ARK addresses 10,9,...,0; every strobe exactly one cycle wide, spaced 3 cycles.
- Start while busy:
  - Pulse startDecrypt at cycles 10 and 60 after the first start.
  - Required: single done at 120; plainText unchanged from the single-block case.
- Reset mid-operation:
  - Assert nReset low asynchronously at cycle 50, release at 55, then start a new block.
  - Required: outputs 0 immediately (between edges); no done; new block completes correctly at +120.
- Parameter sweep at STEP_LATENCY=1 and 7:
  - Required: done at 80 and 320 cycles; same plaintext.
- Back-to-back:
  - startDecrypt held high for two blocks.
  - Required: done pulses 122 cycles apart (120 + DONE + IDLE); both plaintexts correct.
